shift_cnt: RTL

//  Parametrised shift-register counter, successor to the fixed 4-bit ring counter.

---
 rtl/shift_cnt.sv | 83 ++++++++
 1 files changed

// File: rtl/shift_cnt.sv
// rtl/shift_cnt.sv - parametrised ring/Johnson shift counter with load, direction and wrap pulse
// Optional feature macro: SHIFT_CNT_SELF_CORRECT_EN (illegal-state detection and recovery to SEED)
module shift_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q,
    output logic             o_wrap,
    output logic             o_illegal
);

    localparam logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_shifted;
    logic             w_illegal;

    // Next state of a plain shift for the current mode and direction
    always_comb begin
        w_shifted = r_q;
        case ({i_mode, i_dir})
            2'b00:   w_shifted = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            2'b01:   w_shifted = {r_q[0], r_q[WIDTH-1:1]};
            2'b10:   w_shifted = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            default: w_shifted = {~r_q[0], r_q[WIDTH-1:1]};
        endcase
    end

`ifdef SHIFT_CNT_SELF_CORRECT_EN
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0] w_trans;
    logic          w_ring_legal;
    logic          w_john_legal;

    // Legality: ring needs exactly one bit set, Johnson at most one adjacent-bit transition
    always_comb begin
        w_trans = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            w_trans = w_trans + {{(CW-1){1'b0}}, r_q[i] ^ r_q[i+1]};
        end
        w_ring_legal = (r_q != '0) && ((r_q & (r_q - WIDTH'(1))) == '0);
        w_john_legal = (w_trans <= CW'(1));
        w_illegal    = i_mode ? ~w_john_legal : ~w_ring_legal;
    end
`else
    // Without self-correction every state is treated as shiftable
    assign w_illegal = 1'b0;
`endif

    // Counter state and wrap pulse: load beats shift, shift beats hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= SEED;
            r_wrap <= 1'b0;
        end else if (i_load) begin
            r_q    <= i_load_val;
            r_wrap <= 1'b0;
        end else if (i_en) begin
            if (w_illegal) begin
                r_q    <= SEED;
                r_wrap <= 1'b0;
            end else begin
                r_q    <= w_shifted;
                r_wrap <= (w_shifted == SEED);
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_q       = r_q;
    assign o_wrap    = r_wrap;
    assign o_illegal = w_illegal;

endmodule
